// File: rtl/fpm_seq.sv
// fpm_seq: sequential IEEE-754 binary32 multiplier.
// Shift-add mantissa product, RNE rounding, flush-to-zero, handshaked in/out.
module fpm_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_z,
  output logic        nan,
  output logic        inf,
  output logic        zer
);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t state, state_n;

  logic               sgn, s_nan, s_inf, s_zer;
  logic [23:0]        ma, mb;
  logic [47:0]        prod;
  logic [4:0]         cnt;
  logic signed [9:0]  e_r;
  logic [22:0]        mant;
  logic               grd, stk;

  logic accept, xfer;
  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  // operand classification, only consumed on accept
  logic a_z, a_i, a_n, b_z, b_i, b_n;
  logic c_nan, c_inf, c_zer, c_sp;
  assign a_z = (a[30:23] == 8'h00);
  assign b_z = (b[30:23] == 8'h00);
  assign a_i = (a[30:23] == 8'hFF) & (a[22:0] == 23'd0);
  assign b_i = (b[30:23] == 8'hFF) & (b[22:0] == 23'd0);
  assign a_n = (a[30:23] == 8'hFF) & (a[22:0] != 23'd0);
  assign b_n = (b[30:23] == 8'hFF) & (b[22:0] != 23'd0);
  assign c_nan = a_n | b_n | (a_i & b_z) | (b_i & a_z);
  assign c_inf = ~c_nan & (a_i | b_i);
  assign c_zer = ~c_nan & ~c_inf & (a_z | b_z);
  assign c_sp  = c_nan | c_inf | c_zer;

  logic signed [9:0] e_sum;
  assign e_sum = $signed({2'b00, a[30:23]})
               + $signed({2'b00, b[30:23]})
               - 10'sd127;

  logic [24:0] psum;
  assign psum = {1'b0, prod[47:24]}
              + (mb[0] ? {1'b0, ma} : 25'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = c_sp ? DONE : MUL;
      end
      MUL:  if (cnt == 5'd23) state_n = NORM;
      NORM: state_n = DONE;
      DONE: if (xfer) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // rounding and range check on the normalized mantissa
  logic               up, sp;
  logic [23:0]        rsum;
  logic signed [9:0]  e_f;
  logic               r_nan, r_inf, r_zer;
  logic [31:0]        z_c;

  always_comb begin
    up    = grd & (stk | mant[0]);
    rsum  = {1'b0, mant} + {23'd0, up};
    e_f   = e_r + $signed({9'd0, rsum[23]});
    sp    = s_nan | s_inf | s_zer;
    r_nan = s_nan;
    r_inf = s_inf | (~sp & (e_f >= 10'sd255));
    r_zer = s_zer | (~sp & (e_f < 10'sd255) & (e_f <= 10'sd0));
    z_c   = {sgn, e_f[7:0], rsum[22:0]};
    if (r_nan)      z_c = 32'h7FC0_0000;
    else if (r_inf) z_c = {sgn, 8'hFF, 23'd0};
    else if (r_zer) z_c = {sgn, 31'd0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn       <= 1'b0;
      s_nan     <= 1'b0;
      s_inf     <= 1'b0;
      s_zer     <= 1'b0;
      ma        <= '0;
      mb        <= '0;
      prod      <= '0;
      cnt       <= '0;
      e_r       <= '0;
      mant      <= '0;
      grd       <= 1'b0;
      stk       <= 1'b0;
      out_valid <= 1'b0;
      fp_z      <= '0;
      nan       <= 1'b0;
      inf       <= 1'b0;
      zer       <= 1'b0;
    end else begin
      if (accept) begin
        sgn   <= a[31] ^ b[31];
        s_nan <= c_nan;
        s_inf <= c_inf;
        s_zer <= c_zer;
        ma    <= {1'b1, a[22:0]};
        mb    <= {1'b1, b[22:0]};
        prod  <= '0;
        cnt   <= '0;
        e_r   <= e_sum;
      end
      if (state == MUL) begin
        prod <= {psum, prod[23:1]};
        mb   <= mb >> 1;
        cnt  <= cnt + 5'd1;
      end
      if (state == NORM) begin
        mant <= prod[47] ? prod[46:24] : prod[45:23];
        grd  <= prod[47] ? prod[23] : prod[22];
        stk  <= prod[47] ? |prod[22:0] : |prod[21:0];
        e_r  <= e_r + $signed({9'd0, prod[47]});
      end
      // first DONE cycle registers the result; held until transfer
      if (state == DONE && !out_valid) begin
        out_valid <= 1'b1;
        fp_z      <= z_c;
        nan       <= r_nan;
        inf       <= r_inf;
        zer       <= r_zer;
      end
      if (xfer) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpm_seq.sv
// tb_fpm_seq: directed and lightly randomized checks of fpm_seq
// against an integer-arithmetic reference and literal expectations.
module tb_fpm_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_z;
  logic        nan, inf, zer;

  fpm_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .fp_z(fp_z), .nan(nan), .inf(inf), .zer(zer)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] z;
    logic [2:0]  f;
    int          due;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // {special, nan, inf, zer, z}
  function automatic logic [35:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y);
    logic s;
    int ex, ey, e, sh;
    longint unsigned mx, my, p, qq, rem, half;
    bit xz, xi, xn, yz, yi, yn;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xi && yz) || (yi && xz))
      return {1'b1, 3'b100, 32'h7FC00000};
    if (xi || yi) return {1'b1, 3'b010, s, 8'hFF, 23'h0};
    if (xz || yz) return {1'b1, 3'b001, s, 31'h0};
    mx = 64'(x[22:0]) + (64'd1 << 23);
    my = 64'(y[22:0]) + (64'd1 << 23);
    p  = mx * my;
    e  = ex + ey - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end
    qq   = p >> sh;
    rem  = p - (qq << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && qq[0])) qq++;
    if (qq == (64'd1 << 24)) begin
      qq = qq >> 1;
      e++;
    end
    if (e >= 255) return {1'b0, 3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {1'b0, 3'b001, s, 31'h0};
    return {1'b0, 3'b000, s, 8'(e), qq[22:0]};
  endfunction

  // reference: records accepts, retires transfers, flushes on reset
  always @(posedge clk) begin
    logic [35:0] r;
    exp_t        e;
    cyc = cyc + 1;
    if (rst) q.delete();
    else begin
      if (q.size() > 0 && out_valid && out_ready) void'(q.pop_front());
      if (in_valid && in_ready) begin
        r     = ref_mul(a, b);
        e.z   = r[31:0];
        e.f   = r[34:32];
        e.due = cyc + (r[35] ? 1 : 26);
        q.push_back(e);
      end
    end
  end

  // per-cycle compare against the reference
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end else if (q.size() == 0) begin
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
    end else begin
      chk("busy_in_ready", 32'(in_ready), 32'd0);
      chk("out_valid_timing", 32'(out_valid),
          32'(cyc >= q[0].due));
      if (out_valid) begin
        chk("model_z", fp_z, q[0].z);
        chk("model_flags", 32'({nan, inf, zer}), 32'(q[0].f));
      end
    end
  end

  task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ez, input logic [2:0] ef,
                        input int hold);
    bit got;
    a         = va;
    b         = vb;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    got = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    chk("accept", 32'(got), 32'd1);
    if (!got) return;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("result_seen", 32'(got), 32'd1);
    chk("lit_z", fp_z, ez);
    chk("lit_flags", 32'({nan, inf, zer}), 32'(ef));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_z", fp_z, ez);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [35:0] r;
    logic [31:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    chk("reset_z", fp_z, 32'h0);
    chk("reset_flags", 32'({nan, inf, zer}), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 0);
    run_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 0);
    run_op(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010, 0);
    run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 0);
    run_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 0);
    run_op(32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 0);
    run_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, 0);
    run_op(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000, 0);
    run_op(32'h00800000, 32'h3F800000, 32'h00800000, 3'b000, 0);
    run_op(32'h00800000, 32'h3F000000, 32'h00000000, 3'b001, 0);
    run_op(32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 3'b000, 0);
    run_op(32'h80000000, 32'h3F800000, 32'h80000000, 3'b001, 0);
    run_op(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b100, 0);
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b010, 0);
    run_op(32'h00000001, 32'h7F800000, 32'h7FC00000, 3'b100, 0);
    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, 10);
    run_op(32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b010, 4);

    // reset in the middle of a multiply
    a        = 32'h3FC00000;
    b        = 32'h40000000;
    in_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    run_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, 0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      ra[30:23] = 8'(100 + $urandom_range(0, 54));
      rb[30:23] = 8'(100 + $urandom_range(0, 54));
      r = ref_mul(ra, rb);
      run_op(ra, rb, r[31:0], r[34:32], 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
